cam_frame_bridge: RTL and testbench

Parametrised frame bridge between the camera pixel stream and the CNN classifier. It captures whole frames of IMG_DIM×IMG_DIM pixels into a pixel FIFO and streams complete frames to the CNN under ready/valid backpressure. It returns each classification tagged with a frame sequence number. Over-long and short frames are normalised, and frames that cannot fit are dropped and counted.

---
 rtl/cam2cnn_pkg.sv | 28 ++
 rtl/cam_frame_bridge_pix_fifo.sv | 59 +++++
 rtl/cam_frame_bridge.sv | 207 ++++++++++++++++++++
 tb/tb_cam_frame_bridge.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam2cnn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cam2cnn_pkg
// Brief    : Shared state encodings and default sizes for cam_frame_bridge.
// Revision : 1.0
// ============================================================================
package cam2cnn_pkg;

    localparam int c_IMG_DIM = 30;
    localparam int c_PIX_W   = 8;
    localparam int c_DIGIT_W = 4;

    typedef enum logic [2:0] {
        W_IDLE    = 3'd0,
        W_CAPTURE = 3'd1,
        W_PAD     = 3'd2,
        W_FLUSH   = 3'd3,
        W_DROP    = 3'd4
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE   = 2'd0,
        R_STREAM = 2'd1,
        R_WAIT   = 2'd2
    } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/cam_frame_bridge_pix_fifo.sv
`default_nettype none
// ============================================================================
// Module   : pix_fifo
// Brief    : Synchronous first-word-fall-through FIFO with occupancy count.
// Revision : 1.0
// ============================================================================
module pix_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_en_i) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({wr_en_i, rd_en_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Head is forced to zero when empty so stale or unwritten memory never shows.
    assign empty_o   = (count_q == '0);
    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];
    assign count_o   = count_q;

    a_no_overflow : assert property (@(posedge clk) disable iff (!rst)
        !(wr_en_i && (count_q == (AW+1)'(DEPTH))))
        else $error("pix_fifo: write while full");

endmodule
`default_nettype wire

// File: rtl/cam_frame_bridge.sv
`default_nettype none
// ============================================================================
// Module   : cam_frame_bridge
// Brief    : Buffers whole camera frames and streams them to the CNN; returns
//            tagged results. Optional binarisation via CAM2CNN_THRESH_EN.
// Revision : 1.0
// ============================================================================
module cam_frame_bridge
    import cam2cnn_pkg::*;
#(
    parameter int IMG_DIM    = c_IMG_DIM,
    parameter int PIX_W      = c_PIX_W,
    parameter int DIGIT_W    = c_DIGIT_W,
    parameter int FIFO_DEPTH = 1024,
    parameter int FRAME_ID_W = 8,
    parameter int DROP_W     = 16,
    parameter int THRESH     = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sof,
    input  logic                  eof,
    input  logic [PIX_W-1:0]      pix,
    input  logic                  pix_valid,
    output logic [PIX_W-1:0]      cnn_pix,
    output logic                  cnn_pix_valid,
    input  logic                  cnn_ready,
    input  logic [DIGIT_W-1:0]    cnn_digit,
    input  logic                  cnn_digit_valid,
    output logic [DIGIT_W-1:0]    digit,
    output logic                  digit_valid,
    output logic [FRAME_ID_W-1:0] frame_id,
    output logic [DROP_W-1:0]     frames_dropped,
    output logic                  busy
);
    localparam int NUM_PIX = IMG_DIM * IMG_DIM;
    localparam int CW      = $clog2(FIFO_DEPTH) + 1;
    localparam int PCW     = $clog2(NUM_PIX + 1);
    localparam logic [PCW-1:0] c_LAST = PCW'(NUM_PIX - 1);

    if (((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || (FIFO_DEPTH < NUM_PIX)) begin : g_bad_depth
        $error("cam_frame_bridge: FIFO_DEPTH must be a power of two and >= NUM_PIX");
    end
    if ((THRESH < 0) || (THRESH >= (1 << PIX_W))) begin : g_bad_thresh
        $error("cam_frame_bridge: THRESH out of pixel range");
    end

    wr_state_t             wr_state_q, wr_state_d;
    rd_state_t             rd_state_q, rd_state_d;
    logic [PCW-1:0]        wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
    logic [CW-1:0]         frames_ready_q;
    logic [DROP_W-1:0]     drop_q, drop_d;
    logic [FRAME_ID_W-1:0] fid_cnt_q, fid_cnt_d, frame_id_q, frame_id_d;
    logic [DIGIT_W-1:0]    digit_q, digit_d;
    logic                  digit_valid_q, digit_valid_d;

    logic                  fifo_wr, fifo_rd, fifo_empty, frame_done, frame_take;
    logic [PIX_W-1:0]      fifo_wdata, pix_in;
    logic [CW-1:0]         fifo_count, fifo_free;

`ifdef CAM2CNN_THRESH_EN
    assign pix_in = (pix >= PIX_W'(THRESH)) ? {PIX_W{1'b1}} : {PIX_W{1'b0}};
`else
    assign pix_in = pix;
`endif

    assign fifo_free = CW'(FIFO_DEPTH) - fifo_count;

    always_comb begin
        wr_state_d = wr_state_q;
        wr_cnt_d   = wr_cnt_q;
        drop_d     = drop_q;
        fifo_wr    = 1'b0;
        fifo_wdata = '0;
        frame_done = 1'b0;
        unique case (wr_state_q)
            W_IDLE: begin
                if (sof) begin
                    wr_cnt_d = '0;
                    if (fifo_free >= CW'(NUM_PIX)) begin
                        wr_state_d = W_CAPTURE;
                    end else begin
                        wr_state_d = W_DROP;
                        if (drop_q != '1) drop_d = drop_q + 1'b1;
                    end
                end
            end
            W_CAPTURE: begin
                if (pix_valid) begin
                    fifo_wr    = 1'b1;
                    fifo_wdata = pix_in;
                    wr_cnt_d   = wr_cnt_q + 1'b1;
                end
                if (pix_valid && (wr_cnt_q == c_LAST)) begin
                    frame_done = 1'b1;
                    wr_state_d = eof ? W_IDLE : W_FLUSH;
                end else if (eof) begin
                    wr_state_d = W_PAD;
                end
            end
            W_PAD: begin
                fifo_wr  = 1'b1;
                wr_cnt_d = wr_cnt_q + 1'b1;
                if (wr_cnt_q == c_LAST) begin
                    frame_done = 1'b1;
                    wr_state_d = W_IDLE;
                end
            end
            W_FLUSH, W_DROP: begin
                if (eof) wr_state_d = W_IDLE;
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        rd_state_d    = rd_state_q;
        rd_cnt_d      = rd_cnt_q;
        fid_cnt_d     = fid_cnt_q;
        frame_id_d    = frame_id_q;
        digit_d       = digit_q;
        digit_valid_d = 1'b0;
        frame_take    = 1'b0;
        fifo_rd       = 1'b0;
        cnn_pix_valid = 1'b0;
        unique case (rd_state_q)
            R_IDLE: begin
                if (frames_ready_q != '0) begin
                    frame_take = 1'b1;
                    rd_cnt_d   = '0;
                    rd_state_d = R_STREAM;
                end
            end
            R_STREAM: begin
                cnn_pix_valid = !fifo_empty;
                fifo_rd       = !fifo_empty && cnn_ready;
                if (fifo_rd) begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                    if (rd_cnt_q == c_LAST) rd_state_d = R_WAIT;
                end
            end
            R_WAIT: begin
                if (cnn_digit_valid) begin
                    digit_d       = cnn_digit;
                    digit_valid_d = 1'b1;
                    frame_id_d    = fid_cnt_q;
                    fid_cnt_d     = fid_cnt_q + 1'b1;
                    rd_state_d    = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_state_q     <= W_IDLE;
            rd_state_q     <= R_IDLE;
            wr_cnt_q       <= '0;
            rd_cnt_q       <= '0;
            frames_ready_q <= '0;
            drop_q         <= '0;
            fid_cnt_q      <= '0;
            frame_id_q     <= '0;
            digit_q        <= '0;
            digit_valid_q  <= 1'b0;
        end else begin
            wr_state_q     <= wr_state_d;
            rd_state_q     <= rd_state_d;
            wr_cnt_q       <= wr_cnt_d;
            rd_cnt_q       <= rd_cnt_d;
            drop_q         <= drop_d;
            fid_cnt_q      <= fid_cnt_d;
            frame_id_q     <= frame_id_d;
            digit_q        <= digit_d;
            digit_valid_q  <= digit_valid_d;
            // Simultaneous completion and hand-off cancel out.
            case ({frame_done, frame_take})
                2'b10:   frames_ready_q <= frames_ready_q + 1'b1;
                2'b01:   frames_ready_q <= frames_ready_q - 1'b1;
                default: frames_ready_q <= frames_ready_q;
            endcase
        end
    end

    pix_fifo #(
        .WIDTH (PIX_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (fifo_wr),
        .wr_data_i (fifo_wdata),
        .rd_en_i   (fifo_rd),
        .rd_data_o (cnn_pix),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    assign digit          = digit_q;
    assign digit_valid    = digit_valid_q;
    assign frame_id       = frame_id_q;
    assign frames_dropped = drop_q;
    assign busy           = (wr_state_q != W_IDLE) || (rd_state_q != R_IDLE) || !fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_cam_frame_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_cam_frame_bridge
// Brief    : Directed self-checking bench for cam_frame_bridge (IMG_DIM=4, depth 32).
// Revision : 1.0
// ============================================================================
module tb_cam_frame_bridge;
    localparam int N = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sof = 1'b0, eof = 1'b0, pix_valid = 1'b0;
    logic [7:0] pix = '0;
    logic       cnn_ready = 1'b0, cnn_digit_valid = 1'b0;
    logic [3:0] cnn_digit = '0;
    logic [7:0] cnn_pix;
    logic       cnn_pix_valid;
    logic [3:0] digit;
    logic       digit_valid;
    logic [7:0] frame_id;
    logic [15:0] frames_dropped;
    logic       busy;

    cam_frame_bridge #(
        .IMG_DIM(4), .PIX_W(8), .DIGIT_W(4), .FIFO_DEPTH(32),
        .FRAME_ID_W(8), .DROP_W(16), .THRESH(128)
    ) dut (
        .clk(clk), .rst(rst), .sof(sof), .eof(eof), .pix(pix), .pix_valid(pix_valid),
        .cnn_pix(cnn_pix), .cnn_pix_valid(cnn_pix_valid), .cnn_ready(cnn_ready),
        .cnn_digit(cnn_digit), .cnn_digit_valid(cnn_digit_valid),
        .digit(digit), .digit_valid(digit_valid), .frame_id(frame_id),
        .frames_dropped(frames_dropped), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit rand_en = 1'b0;
    logic [7:0] got_q[$];
    logic [3:0] dig_q[$];
    logic [7:0] fid_q[$];
    int dv_run = 0;
    int dv_max = 0;

    // Record every accepted pixel and every result pulse, mid-cycle.
    always @(negedge clk) begin
        if (cnn_pix_valid && cnn_ready) got_q.push_back(cnn_pix);
        if (digit_valid) begin
            dig_q.push_back(digit);
            fid_q.push_back(frame_id);
            dv_run = dv_run + 1;
            if (dv_run > dv_max) dv_max = dv_run;
        end else begin
            dv_run = 0;
        end
    end

    function automatic logic [7:0] exp_pix(input logic [7:0] v);
`ifdef CAM2CNN_THRESH_EN
        return (v >= 8'd128) ? 8'hFF : 8'h00;
`else
        return v;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_en) cnn_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic do_reset();
        rst = 1'b0; sof = 1'b0; eof = 1'b0; pix_valid = 1'b0; cnn_digit_valid = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic send_frame(input int n, input int base, input bit eof_on_last);
        sof = 1'b1;
        tick();
        sof = 1'b0;
        for (int i = 0; i < n; i++) begin
            pix = 8'(base + i);
            pix_valid = 1'b1;
            eof = eof_on_last && (i == n - 1);
            tick();
        end
        pix_valid = 1'b0;
        eof = 1'b0;
        if (!eof_on_last) begin
            eof = 1'b1;
            tick();
            eof = 1'b0;
        end
    endtask

    task automatic wait_pixels(input int target, input string name);
        int t;
        t = 0;
        while (got_q.size() < target && t < 400) begin
            tick();
            t++;
        end
        if (got_q.size() < target) begin
            checks++; failures++;
            $display("FAIL %s timeout: got %0d pixels required %0d", name, got_q.size(), target);
        end
    endtask

    task automatic respond(input logic [3:0] d);
        cnn_digit = d;
        cnn_digit_valid = 1'b1;
        tick();
        cnn_digit_valid = 1'b0;
        tick(); tick();
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b0;
        tick();
        checks++; if (cnn_pix !== 8'h00) begin failures++; $display("FAIL reset_cnn_pix: got %0h required 0", cnn_pix); end
        checks++; if (cnn_pix_valid !== 1'b0) begin failures++; $display("FAIL reset_cnn_pix_valid: got %0b required 0", cnn_pix_valid); end
        checks++; if (digit !== 4'h0 || digit_valid !== 1'b0) begin failures++; $display("FAIL reset_digit: got %0h/%0b required 0/0", digit, digit_valid); end
        checks++; if (frame_id !== 8'h00 || frames_dropped !== 16'h0) begin failures++; $display("FAIL reset_counters: got %0h/%0h required 0/0", frame_id, frames_dropped); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b required 0", busy); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single_frame();
        int b;
        b = got_q.size();
        cnn_ready = 1'b1;
        sof = 1'b1; tick(); sof = 1'b0;
        pix = 8'h10; pix_valid = 1'b1; tick();
        checks++; if (cnn_pix !== exp_pix(8'h10)) begin failures++; $display("FAIL first_pixel_latency: got %0h required %0h", cnn_pix, exp_pix(8'h10)); end
        checks++; if (cnn_pix_valid !== 1'b0) begin failures++; $display("FAIL early_stream: got %0b required 0", cnn_pix_valid); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL busy_capture: got %0b required 1", busy); end
        for (int i = 1; i < N; i++) begin
            pix = 8'(8'h10 + i);
            eof = (i == N - 1);
            tick();
        end
        pix_valid = 1'b0; eof = 1'b0;
        wait_pixels(b + N, "single_stream");
        repeat (5) tick();
        checks++; if (got_q.size() !== b + N) begin failures++; $display("FAIL single_count: got %0d required %0d", got_q.size() - b, N); end
        for (int i = 0; i < N && b + i < got_q.size(); i++) begin
            checks++;
            if (got_q[b + i] !== exp_pix(8'(8'h10 + i))) begin failures++; $display("FAIL single_pix[%0d]: got %0h required %0h", i, got_q[b + i], exp_pix(8'(8'h10 + i))); end
        end
        respond(4'd7);
        checks++; if (dig_q.size() !== 1) begin failures++; $display("FAIL single_result_count: got %0d required 1", dig_q.size()); end
        else begin
            checks++; if (dig_q[0] !== 4'd7 || fid_q[0] !== 8'd0) begin failures++; $display("FAIL single_result: got digit %0d id %0d required 7/0", dig_q[0], fid_q[0]); end
        end
        checks++; if (digit !== 4'd7 || digit_valid !== 1'b0 || frame_id !== 8'd0) begin failures++; $display("FAIL result_hold: got %0d/%0b/%0d required 7/0/0", digit, digit_valid, frame_id); end
        checks++; if (dv_max !== 1) begin failures++; $display("FAIL digit_valid_width: got %0d required 1", dv_max); end
    endtask

    task automatic test_short_long();
        int b;
        logic [7:0] e;
        b = got_q.size();
        cnn_ready = 1'b1;
        send_frame(10, 8'h40, 1'b0);
        wait_pixels(b + N, "short_stream");
        respond(4'd3);
        send_frame(20, 8'h60, 1'b0);
        wait_pixels(b + 2 * N, "long_stream");
        respond(4'd5);
        repeat (5) tick();
        checks++; if (got_q.size() !== b + 2 * N) begin failures++; $display("FAIL short_long_count: got %0d required %0d", got_q.size() - b, 2 * N); end
        for (int i = 0; i < 2 * N && b + i < got_q.size(); i++) begin
            if (i < 10)      e = exp_pix(8'(8'h40 + i));
            else if (i < N)  e = 8'h00;
            else             e = exp_pix(8'(8'h60 + i - N));
            checks++;
            if (got_q[b + i] !== e) begin failures++; $display("FAIL short_long_pix[%0d]: got %0h required %0h", i, got_q[b + i], e); end
        end
        checks++; if (fid_q.size() !== 3) begin failures++; $display("FAIL short_long_results: got %0d required 3", fid_q.size()); end
        else begin
            checks++; if (fid_q[1] !== 8'd1 || fid_q[2] !== 8'd2 || dig_q[1] !== 4'd3 || dig_q[2] !== 4'd5) begin
                failures++; $display("FAIL short_long_ids: got %0d:%0d %0d:%0d required 1:3 2:5", fid_q[1], dig_q[1], fid_q[2], dig_q[2]); end
        end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy: got %0b required 0", busy); end
    endtask

    task automatic test_back_to_back();
        int b, fb;
        do_reset();
        cnn_ready = 1'b0;
        b = got_q.size();
        fb = fid_q.size();
        send_frame(N, 8'h80, 1'b1);
        send_frame(N, 8'h90, 1'b1);
        send_frame(N, 8'hA0, 1'b1);
        tick();
        checks++; if (frames_dropped !== 16'd1) begin failures++; $display("FAIL drop_count: got %0d required 1", frames_dropped); end
        checks++; if (got_q.size() !== b) begin failures++; $display("FAIL pop_without_ready: got %0d required 0", got_q.size() - b); end
        checks++; if (cnn_pix_valid !== 1'b1 || cnn_pix !== exp_pix(8'h80)) begin failures++; $display("FAIL hold_head: got %0b/%0h required 1/%0h", cnn_pix_valid, cnn_pix, exp_pix(8'h80)); end
        cnn_ready = 1'b1;
        wait_pixels(b + N, "b2b_first");
        respond(4'd1);
        wait_pixels(b + 2 * N, "b2b_second");
        respond(4'd2);
        repeat (5) tick();
        checks++; if (got_q.size() !== b + 2 * N) begin failures++; $display("FAIL b2b_count: got %0d required %0d", got_q.size() - b, 2 * N); end
        for (int i = 0; i < 2 * N && b + i < got_q.size(); i++) begin
            checks++;
            if (got_q[b + i] !== exp_pix(8'((i < N) ? (8'h80 + i) : (8'h90 + i - N)))) begin
                failures++; $display("FAIL b2b_pix[%0d]: got %0h required %0h", i, got_q[b + i], exp_pix(8'((i < N) ? (8'h80 + i) : (8'h90 + i - N)))); end
        end
        checks++; if (fid_q.size() !== fb + 2) begin failures++; $display("FAIL b2b_results: got %0d required 2", fid_q.size() - fb); end
        else begin
            checks++; if (fid_q[fb] !== 8'd0 || fid_q[fb + 1] !== 8'd1 || dig_q[fb] !== 4'd1 || dig_q[fb + 1] !== 4'd2) begin
                failures++; $display("FAIL b2b_ids: got %0d:%0d %0d:%0d required 0:1 1:2", fid_q[fb], dig_q[fb], fid_q[fb + 1], dig_q[fb + 1]); end
        end
        checks++; if (frames_dropped !== 16'd1) begin failures++; $display("FAIL drop_hold: got %0d required 1", frames_dropped); end
    endtask

    task automatic test_random_ready();
        int b, fb;
        b = got_q.size();
        fb = fid_q.size();
        rand_en = 1'b1;
        send_frame(N, 8'h20, 1'b1);
        send_frame(N, 8'h30, 1'b0);
        wait_pixels(b + N, "rand_first");
        respond(4'd4);
        wait_pixels(b + 2 * N, "rand_second");
        respond(4'd6);
        rand_en = 1'b0;
        cnn_ready = 1'b1;
        repeat (5) tick();
        checks++; if (got_q.size() !== b + 2 * N) begin failures++; $display("FAIL rand_count: got %0d required %0d", got_q.size() - b, 2 * N); end
        for (int i = 0; i < 2 * N && b + i < got_q.size(); i++) begin
            checks++;
            if (got_q[b + i] !== exp_pix(8'(8'h20 + i))) begin failures++; $display("FAIL rand_pix[%0d]: got %0h required %0h", i, got_q[b + i], exp_pix(8'(8'h20 + i))); end
        end
        checks++; if (fid_q.size() !== fb + 2) begin failures++; $display("FAIL rand_results: got %0d required 2", fid_q.size() - fb); end
        else begin
            checks++; if (fid_q[fb] !== 8'd2 || fid_q[fb + 1] !== 8'd3) begin failures++; $display("FAIL rand_ids: got %0d %0d required 2 3", fid_q[fb], fid_q[fb + 1]); end
        end
    endtask

    task automatic test_reset_mid();
        int b, fb;
        cnn_ready = 1'b1;
        sof = 1'b1; tick(); sof = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pix = 8'(8'h50 + i); pix_valid = 1'b1; tick();
        end
        rst = 1'b0;
        tick();
        checks++; if (digit !== 4'd0 || frame_id !== 8'd0 || frames_dropped !== 16'd0) begin
            failures++; $display("FAIL midcap_reset_regs: got %0d/%0d/%0d required 0/0/0", digit, frame_id, frames_dropped); end
        checks++; if (busy !== 1'b0 || cnn_pix !== 8'h00) begin failures++; $display("FAIL midcap_reset_fifo: got %0b/%0h required 0/0", busy, cnn_pix); end
        rst = 1'b1; pix_valid = 1'b0; tick();
        b = got_q.size();
        send_frame(N, 8'hC0, 1'b1);
        wait_pixels(b + 5, "midstream_pre");
        rst = 1'b0;
        tick();
        checks++; if (cnn_pix_valid !== 1'b0 || cnn_pix !== 8'h00 || busy !== 1'b0) begin
            failures++; $display("FAIL midstream_reset: got %0b/%0h/%0b required 0/0/0", cnn_pix_valid, cnn_pix, busy); end
        rst = 1'b1; tick();
        b = got_q.size();
        fb = fid_q.size();
        send_frame(N, 8'hD0, 1'b1);
        wait_pixels(b + N, "post_reset");
        respond(4'd9);
        checks++; if (got_q.size() !== b + N) begin failures++; $display("FAIL post_reset_count: got %0d required %0d", got_q.size() - b, N); end
        for (int i = 0; i < N && b + i < got_q.size(); i++) begin
            checks++;
            if (got_q[b + i] !== exp_pix(8'(8'hD0 + i))) begin failures++; $display("FAIL post_reset_pix[%0d]: got %0h required %0h", i, got_q[b + i], exp_pix(8'(8'hD0 + i))); end
        end
        checks++; if (fid_q.size() !== fb + 1) begin failures++; $display("FAIL post_reset_results: got %0d required 1", fid_q.size() - fb); end
        else begin
            checks++; if (fid_q[fb] !== 8'd0 || dig_q[fb] !== 4'd9) begin failures++; $display("FAIL post_reset_id: got %0d:%0d required 0:9", fid_q[fb], dig_q[fb]); end
        end
    endtask

`ifdef CAM2CNN_THRESH_EN
    task automatic test_thresh();
        int b;
        logic [7:0] vals [3];
        logic [7:0] want [3];
        vals[0] = 8'd127; vals[1] = 8'd128; vals[2] = 8'd255;
        want[0] = 8'd0;   want[1] = 8'd255; want[2] = 8'd255;
        b = got_q.size();
        cnn_ready = 1'b1;
        sof = 1'b1; tick(); sof = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pix = vals[i]; pix_valid = 1'b1; eof = (i == 2); tick();
        end
        pix_valid = 1'b0; eof = 1'b0;
        wait_pixels(b + N, "thresh_stream");
        respond(4'd1);
        for (int i = 0; i < N && b + i < got_q.size(); i++) begin
            checks++;
            if (got_q[b + i] !== ((i < 3) ? want[i] : 8'h00)) begin
                failures++; $display("FAIL thresh_pix[%0d]: got %0h required %0h", i, got_q[b + i], (i < 3) ? want[i] : 8'h00); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_short_long();
        test_back_to_back();
        test_random_ready();
        test_reset_mid();
`ifdef CAM2CNN_THRESH_EN
        test_thresh();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
